quad_step_decoder: RTL

- Upstream front-end for the 8-bit up/down counter tile.
- Takes raw quadrature-encoder channels A/B from pins, synchronises and debounces each channel, and decodes Gray-code transitions.
- Emits one single-cycle step pulse per detent, plus a held direction bit.
- step_en drives the counter's enable input (ui_in[0]); step_up drives its up_down input (ui_in[1]).

---
 rtl/quad_pkg.sv | 42 ++++
 rtl/quad_debounce.sv | 38 +++
 rtl/quad_step_decoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// Shared Gray-state constants, direction encoding and the quadrature transition classifier
// used by the step decoder.
package quad_pkg;

   localparam logic [1:0] ST_00 = 2'b00;
   localparam logic [1:0] ST_10 = 2'b10;
   localparam logic [1:0] ST_11 = 2'b11;
   localparam logic [1:0] ST_01 = 2'b01;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   typedef enum logic {
      PH_START = 1'b0,
      PH_RUN   = 1'b1
   } phase_t;

   typedef struct packed {
      logic valid;
      logic illegal;
      logic up;
   } edge_t;

   // Classifies one {A,B} transition; up follows the forward cycle 00->10->11->01->00.
   function automatic edge_t edge_dir(input logic [1:0] prev, input logic [1:0] cur);
      edge_t r;
      r = '0;
      if ((prev ^ cur) == 2'b11) begin
         r.illegal = 1'b1;
      end else if (prev != cur) begin
         r.valid = 1'b1;
         case (prev)
            ST_00:   r.up = (cur == ST_10);
            ST_10:   r.up = (cur == ST_11);
            ST_11:   r.up = (cur == ST_01);
            default: r.up = (cur == ST_00);
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/quad_debounce.sv
// Two-flop synchroniser followed by a stability filter: the output follows the
// synchronised input only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module quad_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic       sync_1;
   logic       sync_2;
   logic [7:0] stable_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1     <= 1'b0;
         sync_2     <= 1'b0;
         stable_cnt <= '0;
         dout       <= 1'b0;
      end else begin
         sync_1 <= din;
         sync_2 <= sync_1;
         if (sync_2 == dout) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_LAST) begin
            dout       <= sync_2;
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature front-end: debounced A/B, startup settling window, Gray-code edge decode and
// a signed per-detent accumulator that emits one step pulse plus a held direction.
//
// state    | meaning
// PH_START | settling after reset release; prev_ab tracks filt_ab, no steps or err
// PH_RUN   | normal decode of filt_ab against prev_ab
module quad_step_decoder
   import quad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES  = 4,
   parameter int STEPS_PER_DETENT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       quad_a,
   input  logic       quad_b,
   output logic       step_en,
   output logic       step_up,
   output logic       err,
   output logic [1:0] filt_ab
);

   localparam int               STARTUP_LEN = DEBOUNCE_CYCLES + 3;
   localparam logic [8:0]       START_LAST  = 9'(STARTUP_LEN - 1);
   localparam logic signed [3:0] ACC_MAX    = signed'(4'(STEPS_PER_DETENT - 1));
   localparam logic signed [3:0] ACC_MIN    = -ACC_MAX;

   phase_t            phase;
   phase_t            phase_nxt;
   logic [8:0]        start_cnt;
   logic [1:0]        prev_ab;
   logic signed [3:0] acc;
   logic signed [3:0] acc_nxt;
   logic              step_nxt;
   logic              up_nxt;
   logic              err_nxt;
   edge_t             ed;

   quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (quad_a),
      .dout (filt_ab[1])
   );

   quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (quad_b),
      .dout (filt_ab[0])
   );

   always_comb begin
      phase_nxt = phase;
      if (phase == PH_START && start_cnt == START_LAST) begin
         phase_nxt = PH_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase     <= PH_START;
         start_cnt <= '0;
      end else begin
         phase <= phase_nxt;
         if (phase == PH_START) begin
            start_cnt <= start_cnt + 9'd1;
         end
      end
   end

   // Disabled or settling: the accumulator holds and nothing is reported.
   always_comb begin
      ed       = edge_dir(prev_ab, filt_ab);
      acc_nxt  = acc;
      step_nxt = 1'b0;
      up_nxt   = step_up;
      err_nxt  = 1'b0;
      if (phase == PH_RUN && en) begin
         if (ed.illegal) begin
            err_nxt = 1'b1;
            acc_nxt = '0;
         end else if (ed.valid && ed.up) begin
            if (acc == ACC_MAX) begin
               step_nxt = 1'b1;
               up_nxt   = DIR_UP;
               acc_nxt  = '0;
            end else begin
               acc_nxt = acc + 4'sd1;
            end
         end else if (ed.valid) begin
            if (acc == ACC_MIN) begin
               step_nxt = 1'b1;
               up_nxt   = DIR_DN;
               acc_nxt  = '0;
            end else begin
               acc_nxt = acc - 4'sd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_ab <= '0;
         acc     <= '0;
         step_en <= 1'b0;
         step_up <= 1'b0;
         err     <= 1'b0;
      end else begin
         prev_ab <= filt_ab;
         acc     <= acc_nxt;
         step_en <= step_nxt;
         step_up <= up_nxt;
         err     <= err_nxt;
      end
   end

endmodule
